// File: rtl/mdu_hazard_ctrl.sv
// ID-stage stall generation (register Tuse/Tnew hazards + MDU structural hazard) and the multiply/divide unit with HI/LO.
// MDU ops take MULT_CYCLES/DIV_CYCLES; MDU_MADD_EN enables the signed multiply-accumulate op 7.
module mdu_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic [1:0]  id_tuse_rs,
  input  logic [1:0]  id_tuse_rt,
  input  logic        id_is_md,
  input  logic [4:0]  ex_waddr,
  input  logic [1:0]  ex_tnew,
  input  logic [4:0]  mem_waddr,
  input  logic [1:0]  mem_tnew,
  input  logic [2:0]  ex_md_op,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  output logic        stall,
  output logic        md_busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd7;
`endif
  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        md_busy_q, md_busy_d;
  logic        commit_q, commit_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_n_q, hi_n_d, lo_n_q, lo_n_d;

  // A source stalls when its producer is still further from ready than the consumer is from needing it.
  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] ex_w, input logic [1:0] ex_t,
                                      input logic [4:0] mem_w, input logic [1:0] mem_t);
    logic ex_hit;
    logic mem_hit;
    ex_hit  = (ex_w == src) && (ex_t > tuse);
    mem_hit = (mem_w == src) && (mem_t > tuse);
    return (src != 5'd0) && (tuse != 2'd3) && (ex_hit || mem_hit);
  endfunction

  logic madd_start;
  logic md_start;
  logic stall_rs, stall_rt, stall_md;

`ifdef MDU_MADD_EN
  assign madd_start = (ex_md_op == OP_MADD);
`else
  assign madd_start = 1'b0;
`endif
  assign md_start = (ex_md_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) || madd_start;

  assign stall_rs = src_hazard(id_rs_addr, id_tuse_rs, ex_waddr, ex_tnew, mem_waddr, mem_tnew);
  assign stall_rt = src_hazard(id_rt_addr, id_tuse_rt, ex_waddr, ex_tnew, mem_waddr, mem_tnew);
  assign stall_md = id_is_md & (md_busy_q | md_start);
  assign stall    = stall_rs | stall_rt | stall_md;

  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{ex_a[31]}}, ex_a} * {{32{ex_b[31]}}, ex_b};
  assign prod_u = {32'd0, ex_a} * {32'd0, ex_b};

`ifdef MDU_MADD_EN
  logic [63:0] acc_sum;
  assign acc_sum = {hi_q, lo_q} + prod_s;
`endif

  // Signed divide runs on magnitudes; this also yields 0x80000000/-1 = 0x80000000 rem 0 without a special path.
  logic        div_by_zero;
  logic [31:0] divu_den, a_mag, b_mag, q_mag, r_mag;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  assign div_by_zero = (ex_b == 32'd0);
  assign divu_den    = div_by_zero ? 32'd1 : ex_b;
  assign a_mag       = ex_a[31] ? (~ex_a + 32'd1) : ex_a;
  assign b_mag       = ex_b[31] ? (~ex_b + 32'd1) : divu_den;
  assign q_mag       = a_mag / b_mag;
  assign r_mag       = a_mag % b_mag;
  assign quo_s       = (ex_a[31] ^ ex_b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign rem_s       = ex_a[31] ? (~r_mag + 32'd1) : r_mag;
  assign quo_u       = ex_a / divu_den;
  assign rem_u       = ex_a % divu_den;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_busy_d = md_busy_q;
    commit_d  = commit_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_n_d    = hi_n_q;
    lo_n_d    = lo_n_q;
    case (state_q)
      IDLE: begin
        case (ex_md_op)
          OP_MULT: begin
            {hi_n_d, lo_n_d} = prod_s;
            cnt_d     = MULT_N;
            commit_d  = 1'b1;
            md_busy_d = 1'b1;
            state_d   = BUSY;
          end
          OP_MULTU: begin
            {hi_n_d, lo_n_d} = prod_u;
            cnt_d     = MULT_N;
            commit_d  = 1'b1;
            md_busy_d = 1'b1;
            state_d   = BUSY;
          end
          OP_DIV: begin
            hi_n_d    = rem_s;
            lo_n_d    = quo_s;
            cnt_d     = DIV_N;
            commit_d  = !div_by_zero;
            md_busy_d = 1'b1;
            state_d   = BUSY;
          end
          OP_DIVU: begin
            hi_n_d    = rem_u;
            lo_n_d    = quo_u;
            cnt_d     = DIV_N;
            commit_d  = !div_by_zero;
            md_busy_d = 1'b1;
            state_d   = BUSY;
          end
          OP_MTHI: hi_d = ex_a;
          OP_MTLO: lo_d = ex_a;
`ifdef MDU_MADD_EN
          OP_MADD: begin
            {hi_n_d, lo_n_d} = acc_sum;
            cnt_d     = MULT_N;
            commit_d  = 1'b1;
            md_busy_d = 1'b1;
            state_d   = BUSY;
          end
`endif
          default: ;
        endcase
      end
      BUSY: begin
        // New ops are ignored here; the ID stall keeps them from arriving.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (commit_q) begin
            hi_d = hi_n_q;
            lo_d = lo_n_q;
          end
          md_busy_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      md_busy_q <= 1'b0;
      commit_q  <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      hi_n_q    <= 32'd0;
      lo_n_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_busy_q <= md_busy_d;
      commit_q  <= commit_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_n_q    <= hi_n_d;
      lo_n_q    <= lo_n_d;
    end
  end

  assign md_busy = md_busy_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_mdu_hazard_ctrl.sv
// Bench for mdu_hazard_ctrl: hazard vector table, directed MDU sequences, and random stimulus against a reference model.
module tb_mdu_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  id_rs_addr, id_rt_addr, ex_waddr, mem_waddr;
  logic [1:0]  id_tuse_rs, id_tuse_rt, ex_tnew, mem_tnew;
  logic        id_is_md;
  logic [2:0]  ex_md_op;
  logic [31:0] ex_a, ex_b;
  logic        stall, md_busy;
  logic [31:0] hi, lo;

  mdu_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt), .id_is_md(id_is_md),
    .ex_waddr(ex_waddr), .ex_tnew(ex_tnew), .mem_waddr(mem_waddr), .mem_tnew(mem_tnew),
    .ex_md_op(ex_md_op), .ex_a(ex_a), .ex_b(ex_b),
    .stall(stall), .md_busy(md_busy), .hi(hi), .lo(lo)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: architectural HI/LO, remaining busy cycles and the result waiting to land.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
  int          m_left = 0;
  bit          m_commit = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit src_waits(input logic [4:0] src, input logic [1:0] need_in);
    int ready_ex, ready_mem;
    if (src == 5'd0 || need_in == 2'd3) return 1'b0;
    ready_ex  = (ex_waddr == src) ? int'(ex_tnew) : 0;
    ready_mem = (mem_waddr == src) ? int'(mem_tnew) : 0;
    return (ready_ex > int'(need_in)) || (ready_mem > int'(need_in));
  endfunction

  function automatic bit ref_stall();
    bit starting;
    starting = (ex_md_op >= 3'd1 && ex_md_op <= 3'd4) || (MADD && ex_md_op == 3'd7);
    return src_waits(id_rs_addr, id_tuse_rs) || src_waits(id_rt_addr, id_tuse_rt) ||
           (id_is_md && (m_left > 0 || starting));
  endfunction

  task automatic model_edge();
    int sa, sb;
    longint p;
    logic [63:0] w;
    sa = ex_a;
    sb = ex_b;
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_commit = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_commit) begin
        m_hi = m_phi; m_lo = m_plo;
      end
    end else begin
      case (ex_md_op)
        3'd1: begin p = longint'(sa) * longint'(sb); {m_phi, m_plo} = p; m_left = MULT_N; m_commit = 1'b1; end
        3'd2: begin w = {32'd0, ex_a} * {32'd0, ex_b}; {m_phi, m_plo} = w; m_left = MULT_N; m_commit = 1'b1; end
        3'd3: begin
          m_left = DIV_N;
          m_commit = (ex_b != 32'd0);
          if (ex_a == 32'h8000_0000 && ex_b == 32'hFFFF_FFFF) begin
            m_plo = 32'h8000_0000; m_phi = 32'd0;
          end else if (m_commit) begin
            m_plo = sa / sb; m_phi = sa % sb;
          end
        end
        3'd4: begin
          m_left = DIV_N;
          m_commit = (ex_b != 32'd0);
          if (m_commit) begin m_plo = ex_a / ex_b; m_phi = ex_a % ex_b; end
        end
        3'd5: m_hi = ex_a;
        3'd6: m_lo = ex_a;
        3'd7: if (MADD) begin
          p = longint'(sa) * longint'(sb);
          w = {m_hi, m_lo} + p;
          {m_phi, m_plo} = w; m_left = MULT_N; m_commit = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".stall"}, stall, ref_stall());
    chk({tag, ".md_busy"}, md_busy, m_left > 0);
    chk({tag, ".hi"}, hi, m_hi);
    chk({tag, ".lo"}, lo, m_lo);
    chk({tag, ".op_while_busy"}, md_busy && ex_md_op != 3'd0 && !reset, 1'b0);
  endtask

  task automatic cyc(input string tag);
    @(negedge clk);
    check_model(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic md_run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic id_md, output int nbusy, output int nstall);
    ex_md_op = op; ex_a = a; ex_b = b; id_is_md = id_md;
    nbusy = 0; nstall = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_busy) nbusy++;
      if (stall) nstall++;
      check_model("md_run");
      @(posedge clk);
      model_edge();
      #1;
      ex_md_op = 3'd0;
    end
    id_is_md = 1'b0;
  endtask

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tr, tt;
    logic       md;
    logic [4:0] ew;
    logic [1:0] et;
    logic [4:0] mw;
    logic [1:0] mt;
    logic [2:0] op;
    logic       exp;
  } vec_t;

  vec_t vt[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int nb, ns;
    vt[0]  = '{5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 5'd8, 2'd2, 5'd0, 2'd0, 3'd0, 1'b1};
    vt[1]  = '{5'd0, 5'd0, 2'd1, 2'd3, 1'b0, 5'd0, 2'd2, 5'd0, 2'd0, 3'd0, 1'b0};
    vt[2]  = '{5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 5'd0, 2'd0, 5'd8, 2'd1, 3'd0, 1'b0};
    vt[3]  = '{5'd8, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd8, 2'd1, 3'd0, 1'b1};
    vt[4]  = '{5'd8, 5'd0, 2'd3, 2'd3, 1'b0, 5'd8, 2'd2, 5'd0, 2'd0, 3'd0, 1'b0};
    vt[5]  = '{5'd8, 5'd9, 2'd3, 2'd0, 1'b0, 5'd9, 2'd1, 5'd0, 2'd0, 3'd0, 1'b1};
    vt[6]  = '{5'd0, 5'd9, 2'd3, 2'd2, 1'b0, 5'd9, 2'd2, 5'd9, 2'd2, 3'd0, 1'b0};
    vt[7]  = '{5'd5, 5'd0, 2'd1, 2'd3, 1'b0, 5'd6, 2'd2, 5'd7, 2'd2, 3'd0, 1'b0};
    vt[8]  = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 3'd1, 1'b1};
    vt[9]  = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 3'd5, 1'b0};
    vt[10] = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 3'd3, 1'b0};
    vt[11] = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 3'd7, MADD};
    vt[12] = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 3'd4, 1'b1};

    reset = 1'b1;
    id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_tuse_rs = 2'd3; id_tuse_rt = 2'd3; id_is_md = 1'b0;
    ex_waddr = 5'd0; ex_tnew = 2'd0; mem_waddr = 5'd0; mem_tnew = 2'd0;
    ex_md_op = 3'd0; ex_a = 32'd0; ex_b = 32'd0;
    @(posedge clk); model_edge(); #1;
    cyc("reset");
    chk("reset.md_busy", md_busy, 1'b0);
    chk("reset.hi", hi, 32'd0);
    chk("reset.lo", lo, 32'd0);

    // Combinational hazard table, applied while held in reset so nothing starts.
    for (int i = 0; i < 13; i++) begin
      id_rs_addr = vt[i].rs; id_rt_addr = vt[i].rt; id_tuse_rs = vt[i].tr; id_tuse_rt = vt[i].tt;
      id_is_md = vt[i].md; ex_waddr = vt[i].ew; ex_tnew = vt[i].et;
      mem_waddr = vt[i].mw; mem_tnew = vt[i].mt; ex_md_op = vt[i].op;
      @(negedge clk);
      chk($sformatf("vec%0d.stall", i), stall, vt[i].exp);
      @(posedge clk); model_edge(); #1;
    end
    id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_tuse_rs = 2'd3; id_tuse_rt = 2'd3; id_is_md = 1'b0;
    ex_waddr = 5'd0; mem_waddr = 5'd0; ex_md_op = 3'd0;
    reset = 1'b0;
    cyc("idle");

    md_run(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, nb, ns);
    chk("mult.busy_cycles", nb, MULT_N);
    chk("mult.hi", hi, 32'hFFFF_FFFF);
    chk("mult.lo", lo, 32'hFFFF_FFFA);

    md_run(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, nb, ns);
    chk("multu.hi", hi, 32'd1);
    chk("multu.lo", lo, 32'hFFFF_FFFE);
    chk("mflo.stall_cycles", ns, MULT_N + 1);

    md_run(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, nb, ns);
    chk("div.busy_cycles", nb, DIV_N);
    chk("div.lo", lo, 32'hFFFF_FFFD);
    chk("div.hi", hi, 32'hFFFF_FFFF);

    md_run(3'd3, 32'd1234, 32'd0, 1'b0, nb, ns);
    chk("div0.busy_cycles", nb, DIV_N);
    chk("div0.lo", lo, 32'hFFFF_FFFD);
    chk("div0.hi", hi, 32'hFFFF_FFFF);

    // Reset lands on the third busy cycle of a divide.
    ex_md_op = 3'd3; ex_a = 32'd100; ex_b = 32'd7;
    cyc("abort.start");
    ex_md_op = 3'd0;
    cyc("abort.b1");
    cyc("abort.b2");
    reset = 1'b1;
    cyc("abort.b3");
    reset = 1'b0;
    chk("abort.md_busy", md_busy, 1'b0);
    chk("abort.hi", hi, 32'd0);
    chk("abort.lo", lo, 32'd0);
    ex_md_op = 3'd5; ex_a = 32'h1234;
    cyc("mthi");
    ex_md_op = 3'd0;
    chk("mthi.hi", hi, 32'h1234);
    chk("mthi.md_busy", md_busy, 1'b0);

    md_run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb, ns);
    chk("div_ovf.lo", lo, 32'h8000_0000);
    chk("div_ovf.hi", hi, 32'd0);

    md_run(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, nb, ns);
    chk("divu.lo", lo, 32'h7FFF_FFFC);
    chk("divu.hi", hi, 32'd1);

    ex_md_op = 3'd5; ex_a = 32'd0;
    cyc("madd.mthi");
    ex_md_op = 3'd6; ex_a = 32'hFFFF_FFFF;
    cyc("madd.mtlo");
    md_run(3'd7, 32'd1, 32'd1, 1'b0, nb, ns);
    if (MADD) begin
      chk("madd.busy_cycles", nb, MULT_N);
      chk("madd.hi", hi, 32'd1);
      chk("madd.lo", lo, 32'd0);
    end else begin
      chk("madd.busy_cycles", nb, 0);
      chk("madd.hi", hi, 32'd0);
      chk("madd.lo", lo, 32'hFFFF_FFFF);
    end

    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 59) == 0);
      id_rs_addr = 5'($urandom_range(0, 3));
      id_rt_addr = 5'($urandom_range(0, 3));
      id_tuse_rs = 2'($urandom_range(0, 3));
      id_tuse_rt = 2'($urandom_range(0, 3));
      id_is_md   = 1'($urandom_range(0, 1));
      ex_waddr   = 5'($urandom_range(0, 3));
      ex_tnew    = 2'($urandom_range(0, 3));
      mem_waddr  = 5'($urandom_range(0, 3));
      mem_tnew   = 2'($urandom_range(0, 3));
      if (m_left == 0 && $urandom_range(0, 2) == 0) ex_md_op = 3'($urandom_range(1, 7));
      else ex_md_op = 3'd0;
      case ($urandom_range(0, 5))
        0: ex_a = 32'd0;
        1: ex_a = 32'h8000_0000;
        2: ex_a = 32'hFFFF_FFFF;
        default: ex_a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: ex_b = 32'd0;
        1: ex_b = 32'h8000_0000;
        2: ex_b = 32'hFFFF_FFFF;
        default: ex_b = $urandom;
      endcase
      cyc("rand");
    end
    reset = 1'b0;
    ex_md_op = 3'd0;
    cyc("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
